// File: rtl/lane_hit_pkg.sv
// Purpose : shared types, constants and saturating helper for the lane hit scorer.
// Latency : n/a (package only).
// Backpressure: n/a; contents are lane_state_t, KEY_NONE, CLEAR_KEY_DEFAULT, sat_add().
package lane_hit_pkg;

  typedef enum logic [1:0] {IDLE, HELD, LOCK} lane_state_t;

  localparam logic [7:0] KEY_NONE          = 8'h00;
  localparam logic [7:0] CLEAR_KEY_DEFAULT = 8'h2c;

  // min(a + b, max); the 33-bit sum keeps the comparison free of wrap-around.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max}) sat_add = max;
    else                 sat_add = s[31:0];
  endfunction

endpackage

// File: rtl/lane_judge.sv
// Purpose : one lane's hit/miss judge (IDLE/HELD/LOCK FSM plus registered in-window flag).
// Latency : hit_o/miss_o are combinational events of the current cycle; the state updates next edge.
// Backpressure: none; ports clk_i, rst_ni (sync, active-low), keycode_i, key_i, y_i -> hit_o, miss_o.
module lane_judge
  import lane_hit_pkg::*;
#(
  parameter int Y_W    = 10,
  parameter int WIN_LO = 370,
  parameter int WIN_HI = 399
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [7:0]     keycode_i,
  input  logic [7:0]     key_i,
  input  logic [Y_W-1:0] y_i,
  output logic           hit_o,
  output logic           miss_o
);

  localparam logic [Y_W-1:0] LO = Y_W'(WIN_LO);
  localparam logic [Y_W-1:0] HI = Y_W'(WIN_HI);

  lane_state_t state_q, state_d;
  logic        in_win_q;
  logic        in_win;
  logic        pressed;

  assign in_win  = (y_i >= LO) && (y_i <= HI);
  assign pressed = (keycode_i == key_i);

  always_comb begin
    state_d = state_q;
    hit_o   = 1'b0;
    miss_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pressed && in_win) begin
          state_d = HELD;
        end else if (in_win_q && !in_win) begin
          // Tile just left the window without ever being pressed.
          miss_o = 1'b1;
        end
      end
      HELD: begin
        // Release scores even if the tile has already left the window.
        if (!pressed) begin
          state_d = LOCK;
          hit_o   = 1'b1;
        end
      end
      LOCK: begin
        // Stay locked for the rest of this window visit so re-presses never rescore.
        if (!in_win) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      in_win_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_win_q <= in_win;
    end
  end

endmodule

// File: rtl/lane_hit_scorer.sv
// Purpose : per-lane hit judging plus score/combo/miss accumulators; macro LANE_HIT_SCORER_COMBO_MULT_EN scales hits by combo tier.
// Latency : score, combo, miss_count, kill and miss all update one cycle after the sampled inputs.
// Backpressure: none; ports Clk, Reset_n, keycode, lane_key, lane_y, speed -> score, combo, miss_count, kill, miss.
module lane_hit_scorer
  import lane_hit_pkg::*;
#(
  parameter int             NLANES    = 4,
  parameter int             Y_W       = 10,
  parameter int             WIN_LO    = 370,
  parameter int             WIN_HI    = 399,
  parameter int             SCORE_W   = 8,
  parameter int             COMBO_W   = 6,
  parameter logic [7:0]     CLEAR_KEY = CLEAR_KEY_DEFAULT
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [7:0]              keycode,
  input  logic [NLANES*8-1:0]     lane_key,
  input  logic [NLANES*Y_W-1:0]   lane_y,
  input  logic [3:0]              speed,
  output logic [SCORE_W-1:0]      score,
  output logic [COMBO_W-1:0]      combo,
  output logic [7:0]              miss_count,
  output logic [NLANES-1:0]       kill,
  output logic [NLANES-1:0]       miss
);

  localparam int          IW        = SCORE_W + 4;
  localparam int          CNT_W     = 4;
  localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);
  localparam logic [31:0] COMBO_MAX = 32'((64'd1 << COMBO_W) - 64'd1);

  logic [NLANES-1:0]  hit_ev, miss_ev;
  logic [CNT_W-1:0]   n_hit, n_miss;
  logic [IW-1:0]      per_hit, inc;

  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [7:0]         mc_q, mc_d;
  logic [NLANES-1:0]  kill_q, miss_q;

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    lane_judge #(
      .Y_W    (Y_W),
      .WIN_LO (WIN_LO),
      .WIN_HI (WIN_HI)
    ) u_judge (
      .clk_i     (Clk),
      .rst_ni    (Reset_n),
      .keycode_i (keycode),
      .key_i     (lane_key[8*g +: 8]),
      .y_i       (lane_y[Y_W*g +: Y_W]),
      .hit_o     (hit_ev[g]),
      .miss_o    (miss_ev[g])
    );
  end

  always_comb begin
    n_hit  = '0;
    n_miss = '0;
    for (int i = 0; i < NLANES; i++) begin
      n_hit  = n_hit  + CNT_W'(hit_ev[i]);
      n_miss = n_miss + CNT_W'(miss_ev[i]);
    end
  end

`ifdef LANE_HIT_SCORER_COMBO_MULT_EN
  // Tier comes from the combo held before this cycle's update.
  logic [1:0] tier;
  always_comb begin
    if (32'(combo_q) >= 32'd16)     tier = 2'd2;
    else if (32'(combo_q) >= 32'd8) tier = 2'd1;
    else                            tier = 2'd0;
  end
  assign per_hit = IW'(speed >> 1) << tier;
`else
  assign per_hit = IW'(speed >> 1);
`endif

  assign inc = IW'(n_hit) * per_hit;

  always_comb begin
    score_d = SCORE_W'(sat_add(32'(score_q), 32'(inc), SCORE_MAX));
    combo_d = (|miss_ev) ? '0 : COMBO_W'(sat_add(32'(combo_q), 32'(n_hit), COMBO_MAX));
    mc_d    = 8'(sat_add(32'(mc_q), 32'(n_miss), 32'd255));
    // Clear key wipes the accumulators but leaves the lane FSMs and pulses alone.
    if (keycode == CLEAR_KEY) begin
      score_d = '0;
      combo_d = '0;
      mc_d    = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      score_q <= '0;
      combo_q <= '0;
      mc_q    <= '0;
      kill_q  <= '0;
      miss_q  <= '0;
    end else begin
      score_q <= score_d;
      combo_q <= combo_d;
      mc_q    <= mc_d;
      kill_q  <= hit_ev;
      miss_q  <= miss_ev;
    end
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign miss_count = mc_q;
  assign kill       = kill_q;
  assign miss       = miss_q;

endmodule

// File: tb/tb_lane_hit_scorer.sv
module tb_lane_hit_scorer;

  localparam int NL = 4;
  localparam int YW = 10;
  localparam int LO = 370;
  localparam int HI = 399;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [7:0]        keycode;
  logic [NL*8-1:0]   lane_key;
  logic [NL*YW-1:0]  lane_y;
  logic [3:0]        speed;
  logic [7:0]        score;
  logic [5:0]        combo;
  logic [7:0]        miss_count;
  logic [NL-1:0]     kill;
  logic [NL-1:0]     miss;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int ys [NL];

  // Reference model state: per-lane phase (0 free, 1 key down in window, 2 already scored this visit).
  int        m_ph [NL];
  bit        m_was_in [NL];
  int        m_score, m_combo, m_mc;
  logic [NL-1:0] m_kill, m_miss;

  lane_hit_scorer dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .keycode    (keycode),
    .lane_key   (lane_key),
    .lane_y     (lane_y),
    .speed      (speed),
    .score      (score),
    .combo      (combo),
    .miss_count (miss_count),
    .kill       (kill),
    .miss       (miss)
  );

  always #5 Clk = ~Clk;

  assign lane_key = {8'h09, 8'h07, 8'h16, 8'h04};
  for (genvar g = 0; g < NL; g++) begin : g_y
    assign lane_y[YW*g +: YW] = ys[g][YW-1:0];
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Behavioural model: evaluated from the inputs present at each rising edge.
  always @(posedge Clk) begin
    int nh, nm, per;
    bit inw, pr;
    logic [NL-1:0] k, ms;
    if (!Reset_n) begin
      for (int i = 0; i < NL; i++) begin
        m_ph[i] = 0;
        m_was_in[i] = 1'b0;
      end
      m_score = 0; m_combo = 0; m_mc = 0; m_kill = '0; m_miss = '0;
    end else begin
      nh = 0; nm = 0; k = '0; ms = '0;
      for (int i = 0; i < NL; i++) begin
        inw = (ys[i] >= LO) && (ys[i] <= HI);
        pr  = (keycode == lane_key[8*i +: 8]);
        if (m_ph[i] == 0) begin
          if (pr && inw) m_ph[i] = 1;
          else if (m_was_in[i] && !inw) begin ms[i] = 1'b1; nm++; end
        end else if (m_ph[i] == 1) begin
          if (!pr) begin m_ph[i] = 2; k[i] = 1'b1; nh++; end
        end else begin
          if (!inw) m_ph[i] = 0;
        end
        m_was_in[i] = inw;
      end
      per = int'(speed) / 2;
`ifdef LANE_HIT_SCORER_COMBO_MULT_EN
      if (m_combo >= 16)     per = per * 4;
      else if (m_combo >= 8) per = per * 2;
`endif
      if (keycode == 8'h2c) begin
        m_score = 0; m_combo = 0; m_mc = 0;
      end else begin
        m_score = imin(m_score + nh * per, 255);
        m_combo = (nm > 0) ? 0 : imin(m_combo + nh, 63);
        m_mc    = imin(m_mc + nm, 255);
      end
      m_kill = k;
      m_miss = ms;
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      cmp("score",      int'(score),      m_score);
      cmp("combo",      int'(combo),      m_combo);
      cmp("miss_count", int'(miss_count), m_mc);
      cmp("kill",       int'(kill),       int'(m_kill));
      cmp("miss",       int'(miss),       int'(m_miss));
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic do_hit(input int spd);
    ys[0] = 380; keycode = 8'h00; tick();
    keycode = 8'h04; tick();
    speed = 4'(spd); keycode = 8'h00; tick();
    ys[0] = 100; tick();
  endtask

  initial begin
    int r, idx;
    Reset_n = 1'b0; keycode = 8'h04; speed = 4'd6;
    ys[0] = 380; ys[1] = 100; ys[2] = 100; ys[3] = 100;
    tick(); tick();
    chk_en = 1'b1;
    cmp("rst_score", int'(score), 0);
    cmp("rst_combo", int'(combo), 0);
    cmp("rst_mc",    int'(miss_count), 0);
    cmp("rst_kill",  int'(kill), 0);

    // Single hit on lane 0.
    Reset_n = 1'b1; keycode = 8'h04;
    tick(); tick(); tick();
    keycode = 8'h00; tick();
    cmp("hit_kill",  int'(kill), 1);
    cmp("hit_score", int'(score), 3);
    cmp("hit_combo", int'(combo), 1);
    tick();
    cmp("hit_kill_drop", int'(kill), 0);

    // Re-press inside the same visit must not rescore.
    ys[0] = 385; keycode = 8'h04; tick();
    keycode = 8'h00; tick(); tick();
    cmp("lock_score", int'(score), 3);
    ys[0] = 400; tick();
    ys[0] = 375; tick();
    keycode = 8'h04; tick();
    keycode = 8'h00; tick();
    cmp("rehit_score", int'(score), 6);
    cmp("rehit_combo", int'(combo), 2);
    ys[0] = 100; tick();
    cmp("leave_no_miss", int'(miss_count), 0);

    // Lane 1 tile passes through unhit.
    ys[1] = 398; tick();
    ys[1] = 399; tick();
    ys[1] = 400; tick();
    cmp("miss_pulse", int'(miss), 2);
    cmp("miss_combo", int'(combo), 0);
    cmp("miss_mc",    int'(miss_count), 1);
    ys[1] = 100; tick();
    cmp("miss_drop",  int'(miss), 0);

`ifdef LANE_HIT_SCORER_COMBO_MULT_EN
    repeat (8) do_hit(0);
    cmp("mult_combo8", int'(combo), 8);
    do_hit(4);
    cmp("mult_score", int'(score), 10);
`else
    repeat (35) do_hit(15);
    do_hit(6);
    cmp("pre_sat_score", int'(score), 254);
    do_hit(8);
    cmp("sat_score", int'(score), 255);
`endif

    // Clear key lands on the same cycle as a release (hit event).
    ys[0] = 380; keycode = 8'h00; tick();
    keycode = 8'h04; tick();
    keycode = 8'h2c; tick();
    cmp("clr_score", int'(score), 0);
    cmp("clr_combo", int'(combo), 0);
    cmp("clr_mc",    int'(miss_count), 0);
    cmp("clr_kill",  int'(kill), 1);
    ys[0] = 100; keycode = 8'h00; tick();

    // Randomised traffic: tiles drift downward, keys held for random stretches.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NL; i++) begin
        ys[i] = ys[i] + int'($urandom_range(0, 3));
        if (ys[i] > 420) ys[i] = 340 + int'($urandom_range(0, 20));
      end
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        keycode = keycode;
      end else if (r < 70) begin
        keycode = 8'h00;
      end else if (r < 96) begin
        idx = int'($urandom_range(0, NL - 1));
        keycode = lane_key[8*idx +: 8];
      end else begin
        keycode = 8'h2c;
      end
      if ($urandom_range(0, 19) == 0) speed = 4'($urandom_range(0, 15));
      Reset_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    Reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
